// File: rtl/mask_sched_if.sv
// mask_sched_if -- handshake bundle between the outlier-mask stage, the
// scheduler and the two downstream precision paths.
//   data_in/ind_in/data_in_valid/data_in_ready : input vector + outlier flags
//   low_out/low_out_valid/low_out_ready        : masked vector, low-precision path
//   hi_out/hi_idx/hi_last/hi_out_valid/ready   : flagged elements, one per beat
//   hi_count, busy                             : status of the vector in flight
// master = producer/consumer side (testbench), slave = scheduler.
interface mask_sched_if #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1
);
    localparam int N  = IN_SIZE * IN_PARALLELISM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    logic [N-1:0][IN_WIDTH-1:0] data_in;
    logic [N-1:0]               ind_in;
    logic                       data_in_valid;
    logic                       data_in_ready;
    logic [N-1:0][IN_WIDTH-1:0] low_out;
    logic                       low_out_valid;
    logic                       low_out_ready;
    logic [IN_WIDTH-1:0]        hi_out;
    logic [IW-1:0]              hi_idx;
    logic                       hi_last;
    logic                       hi_out_valid;
    logic                       hi_out_ready;
    logic [CW-1:0]              hi_count;
    logic                       busy;

    modport master (
        output data_in, ind_in, data_in_valid, low_out_ready, hi_out_ready,
        input  data_in_ready, low_out, low_out_valid, hi_out, hi_idx, hi_last,
               hi_out_valid, hi_count, busy
    );

    modport slave (
        input  data_in, ind_in, data_in_valid, low_out_ready, hi_out_ready,
        output data_in_ready, low_out, low_out_valid, hi_out, hi_idx, hi_last,
               hi_out_valid, hi_count, busy
    );
endinterface

// File: rtl/mask_sched.sv
// mask_sched -- splits one element vector into a low-precision vector
// (flagged elements zeroed, one beat) and a stream of the flagged elements
// for the high-precision path (one element per beat, ascending index).
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mask_sched_if.slave (input, low and hi channels, status)
module mask_sched #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1
) (
    input  logic        clk,
    input  logic        rst,
    mask_sched_if.slave bus
);
    localparam int N  = IN_SIZE * IN_PARALLELISM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic [N-1:0][IN_WIDTH-1:0] data_q;     // raw capture, source of hi beats
    logic [N-1:0][IN_WIDTH-1:0] low_q, low_d;
    logic [N-1:0]               pend_q, pend_nxt;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       low_vld_q;
    logic [IW-1:0]              idx;
    logic                       cap, low_hs, hi_hs, hi_vld;

    // per-lane masking of the incoming vector
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign low_d[g] = bus.ind_in[g] ? '0 : bus.data_in[g];
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < N; i++) cnt_d = cnt_d + CW'(bus.ind_in[i]);
    end

    // lowest set bit of pend wins
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) if (pend_q[i]) idx = IW'(i);
    end

    assign hi_vld = (state_q == ISSUE) && (|pend_q);
    assign low_hs = low_vld_q && bus.low_out_ready;
    assign hi_hs  = hi_vld && bus.hi_out_ready;
    // x & (x-1) drops exactly the bit being issued this cycle
    assign pend_nxt = hi_hs ? (pend_q & (pend_q - N'(1))) : pend_q;

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.data_in_valid) begin
                    cap     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // both channels drained, possibly in this very cycle
                if ((!low_vld_q || low_hs) && (pend_nxt == '0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            low_q     <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            low_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                data_q    <= bus.data_in;
                low_q     <= low_d;
                pend_q    <= bus.ind_in;
                cnt_q     <= cnt_d;
                low_vld_q <= 1'b1;
            end else begin
                pend_q <= pend_nxt;
                if (low_hs) low_vld_q <= 1'b0;
            end
        end
    end

    // gated with rst so the input is refused while reset is held
    assign bus.data_in_ready = rst && (state_q == IDLE);
    assign bus.low_out       = low_q;
    assign bus.low_out_valid = low_vld_q;
    assign bus.hi_out        = data_q[idx];
    assign bus.hi_idx        = idx;
    assign bus.hi_last       = $onehot(pend_q);
    assign bus.hi_out_valid  = hi_vld;
    assign bus.hi_count      = cnt_q;
    assign bus.busy          = (state_q == ISSUE);
endmodule

// File: tb/tb_mask_sched.sv
module tb_mask_sched;
    localparam int W   = 16;
    localparam int SZ  = 4;
    localparam int PAR = 1;
    localparam int N   = SZ * PAR;
    localparam int LIM = 64;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mask_sched_if #(.IN_WIDTH(W), .IN_SIZE(SZ), .IN_PARALLELISM(PAR)) bus ();
    mask_sched #(.IN_WIDTH(W), .IN_SIZE(SZ), .IN_PARALLELISM(PAR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_in_ready"}, bus.data_in_ready, 1'b1);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_low_vld"}, bus.low_out_valid, 1'b0);
        check({tag, "_hi_vld"}, bus.hi_out_valid, 1'b0);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = W'($urandom);
        return v;
    endfunction

    // mode 0: readies always 1; 1: random; 2: hi toggles 1,0,.. low 1;
    // 3: low held off for 5 cycles, hi 1.  Call at a negedge with DUT idle.
    task automatic run_vec(input vec_t d, input logic [N-1:0] f, input int mode,
                           input bit chk_period);
        int   q[$];
        vec_t lexp;
        bit   low_done;
        int   cyc, pop;
        logic lr, hr;
        for (int i = 0; i < N; i++) begin
            lexp[i] = f[i] ? '0 : d[i];
            if (f[i]) q.push_back(i);
        end
        pop = q.size();
        check("in_ready_before", bus.data_in_ready, 1'b1);
        bus.data_in       = d;
        bus.ind_in        = f;
        bus.data_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs: captured vector must not follow them
        bus.data_in_valid = 1'b0;
        bus.data_in       = rand_vec();
        bus.ind_in        = N'($urandom);
        low_done = 1'b0;
        cyc      = 0;
        while ((!low_done || q.size() != 0) && cyc < LIM) begin
            check("busy", bus.busy, 1'b1);
            check("in_ready_issue", bus.data_in_ready, 1'b0);
            check("hi_count", bus.hi_count, pop);
            check("low_vld", bus.low_out_valid, !low_done);
            if (!low_done) check("low_out", bus.low_out, lexp);
            check("hi_vld", bus.hi_out_valid, q.size() != 0);
            check("hi_last", bus.hi_last, q.size() == 1);
            if (q.size() != 0) begin
                check("hi_out", bus.hi_out, d[q[0]]);
                check("hi_idx", bus.hi_idx, q[0]);
            end
            case (mode)
                0:       begin lr = 1'b1; hr = 1'b1; end
                2:       begin lr = 1'b1; hr = (cyc % 2 == 0); end
                3:       begin lr = (cyc >= 5); hr = 1'b1; end
                default: begin lr = ($urandom_range(0, 3) != 0); hr = ($urandom_range(0, 3) != 0); end
            endcase
            bus.low_out_ready = lr;
            bus.hi_out_ready  = hr;
            @(posedge clk);
            if (!low_done && lr) low_done = 1'b1;
            if (q.size() != 0 && hr) q.delete(0);
            @(negedge clk);
            cyc++;
        end
        check("timeout", cyc < LIM, 1'b1);
        chk_idle("after_vec");
        check("hi_last_idle", bus.hi_last, 1'b0);
        if (chk_period) check("issue_cycles", cyc, (pop > 1) ? pop : 1);
    endtask

    initial begin
        vec_t d;
        bus.data_in       = '0;
        bus.ind_in        = '0;
        bus.data_in_valid = 1'b0;
        bus.low_out_ready = 1'b0;
        bus.hi_out_ready  = 1'b0;

        // reset held
        #2;
        check("rst_in_ready", bus.data_in_ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_low_vld", bus.low_out_valid, 1'b0);
        check("rst_hi_vld", bus.hi_out_valid, 1'b0);
        check("rst_hi_count", bus.hi_count, 0);
        check("rst_low_out", bus.low_out, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle("post_rst");

        // directed vectors A,B,C,D at indices 0..3
        d[0] = 16'hAAAA; d[1] = 16'hBBBB; d[2] = 16'hCCCC; d[3] = 16'hDDDD;
        run_vec(d, 4'b0000, 0, 1'b1);
        run_vec(d, 4'b1010, 0, 1'b1);
        run_vec(d, 4'b1111, 2, 1'b0);
        run_vec(d, 4'b0100, 3, 1'b0);

        // reset while two flags are pending
        bus.data_in       = d;
        bus.ind_in        = 4'b1010;
        bus.data_in_valid = 1'b1;
        bus.low_out_ready = 1'b0;
        bus.hi_out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.data_in_valid = 1'b0;
        check("pre_rst_hi_vld", bus.hi_out_valid, 1'b1);
        check("pre_rst_low_vld", bus.low_out_valid, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_hi_vld", bus.hi_out_valid, 1'b0);
        check("arst_low_vld", bus.low_out_valid, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_in_ready", bus.data_in_ready, 1'b0);
        check("arst_hi_count", bus.hi_count, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.low_out_ready = 1'b1;
        bus.hi_out_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle("rel");
        run_vec(rand_vec(), 4'b0011, 1, 1'b0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            int m;
            m = (k % 3 == 0) ? 0 : 1;
            run_vec(rand_vec(), N'($urandom), m, m == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
